// File: rtl/icache_refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_pkg
//  Purpose  : Shared state encoding and word-size constant for the
//             instruction-cache refill engine.
//  Revision : 1.0 - initial release
// ============================================================================
package icache_refill_pkg;

  // Bytes fetched from the byte-wide RAM for one instruction word (RV32).
  localparam int unsigned c_word_bytes = 4;

  // Refill engine states.
  typedef enum logic [1:0] {
    IR_IDLE = 2'd0,
    IR_REQ  = 2'd1,
    IR_READ = 2'd2,
    IR_WB   = 2'd3
  } ir_state_t;

endpackage : icache_refill_pkg
`default_nettype wire

// File: rtl/icache_refill_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_if
//  Purpose  : Byte-wide RAM port between the refill engine (master) and the
//             memory arbiter / RAM (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_refill_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;   // request for the shared RAM port
  logic              mem_grant; // arbiter grant, held while mem_req is high
  logic [ADDR_W-1:0] mem_a;     // byte address
  logic              mem_wr;    // write strobe (the refill engine only reads)
  logic [7:0]        mem_din;   // read data, one cycle after its address

  modport master (
    output mem_req,
    output mem_a,
    output mem_wr,
    input  mem_grant,
    input  mem_din
  );

  modport slave (
    input  mem_req,
    input  mem_a,
    input  mem_wr,
    output mem_grant,
    output mem_din
  );
endinterface : icache_refill_if
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill
//  Purpose  : On an instruction-cache miss, win the shared RAM port, read the
//             four bytes of the missed word, assemble them little-endian and
//             pulse the cache write path for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = c_word_bytes
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    cache_hit,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    flush,
  icache_refill_if.master         mem,
  output logic [8*WORD_BYTES-1:0] refill_data,
  output logic                    refill_we,
  output logic                    refill_block,
  output logic                    busy
);

  // Byte counter runs 0..WORD_BYTES inclusive: the extra count collects the
  // last byte, which arrives one cycle after its address.
  localparam int K_W = $clog2(WORD_BYTES + 1);

  ir_state_t                 r_state;
  logic [K_W-1:0]            r_k;
  logic [ADDR_W-1:0]         r_base;
  logic [ADDR_W-1:0]         r_mem_a;
  logic                      r_mem_req;
  logic                      r_we;
  logic                      r_busy;
  logic [8*WORD_BYTES-1:0]   r_data;

  logic [ADDR_W-1:0]         w_base;
  logic [K_W-1:0]            w_k_next;
  logic [K_W-1:0]            w_lane;
  logic [ADDR_W-1:0]         w_addr_next;
  logic                      w_unused_addr_lo;

  // Word-aligned base of the missed fetch; the byte offset is irrelevant.
  assign w_base           = {miss_addr[ADDR_W-1:2], 2'b00};
  assign w_unused_addr_lo = ^miss_addr[1:0];
  assign w_k_next         = r_k + K_W'(1);
  assign w_lane           = r_k - K_W'(1);
  assign w_addr_next      = r_base + ADDR_W'(w_k_next);

  // Refill sequencer: state, byte counter, address and assembled word.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= IR_IDLE;
      r_k       <= '0;
      r_base    <= '0;
      r_mem_a   <= '0;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_data    <= '0;
    end else if (rdy_in) begin
      if (flush && (r_state != IR_IDLE)) begin
        // Redirect: abandon the refill and anything captured so far.
        r_state   <= IR_IDLE;
        r_k       <= '0;
        r_mem_a   <= '0;
        r_mem_req <= 1'b0;
        r_we      <= 1'b0;
        r_busy    <= 1'b0;
        r_data    <= '0;
      end else begin
        case (r_state)
          IR_IDLE: begin
            if (!cache_hit && !flush) begin
              r_base    <= w_base;
              r_k       <= '0;
              r_mem_req <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= IR_REQ;
            end
          end
          IR_REQ: begin
            if (mem.mem_grant) begin
              r_k     <= '0;
              r_mem_a <= r_base;
              r_state <= IR_READ;
            end
          end
          IR_READ: begin
            // Byte k-1 is on mem_din now, addressed in the previous cycle.
            if (r_k != '0) begin
              r_data[{w_lane, 3'b000} +: 8] <= mem.mem_din;
            end
            r_k <= w_k_next;
            if (r_k == K_W'(WORD_BYTES)) begin
              r_mem_req <= 1'b0;
              r_mem_a   <= '0;
              r_we      <= 1'b1;
              r_state   <= IR_WB;
            end else if (r_k != K_W'(WORD_BYTES - 1)) begin
              // On the last address the bus simply holds base+3.
              r_mem_a <= w_addr_next;
            end
          end
          IR_WB: begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IR_IDLE;
          end
          default: begin
            r_state <= IR_IDLE;
          end
        endcase
      end
    end
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_a    = r_mem_a;
  assign mem.mem_wr   = 1'b0;

  // A redirect arriving during write-back must still kill the write.
  assign refill_we    = r_we & ~flush;
  assign refill_block = r_we & ~flush;
  assign refill_data  = r_data;
  assign busy         = r_busy;

endmodule : icache_refill
`default_nettype wire
